// File: rtl/spi_frame_loader.sv
// rtl/spi_frame_loader.sv - SPI mode-0 slave, oversampled in clk, emitting framebuffer writes and swap requests.
module spi_frame_loader #(
  parameter int         ADDR_WIDTH = 11,
  parameter logic [7:0] MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [15:0]           fb_data,
  output logic                  swap_req,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, IGNORE} state_t;

  state_t                state, state_n;
  logic                  sclk_s1, sclk_s2, sclk_prev;
  logic                  ss_s1, ss_s2, ss_prev;
  logic                  mosi_s1, mosi_s2;
  logic                  armed;
  logic [2:0]            bit_cnt;
  logic [6:0]            rx_sr;
  logic [7:0]            miso_sr, last_byte;
  logic                  boundary;
  logic [7:0]            hi_byte, hi_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n, fb_addr_n;
  logic [15:0]           fb_data_n, word;
  logic                  fb_we_n, swap_n;

  logic       sclk_rise, sclk_fall, ss_rise, ss_fall, start, byte_done;
  logic [7:0] rx_byte;

  assign sclk_rise = ~sclk_prev & sclk_s2;
  assign sclk_fall = sclk_prev & ~sclk_s2;
  assign ss_rise   = ~ss_prev & ss_s2;
  assign ss_fall   = ss_prev & ~ss_s2;
  assign start     = (state == IDLE) && armed && ss_fall;
  // ss rising in the same cycle as the 8th sclk edge wins and drops the byte
  assign byte_done = (state != IDLE) && sclk_rise && (bit_cnt == 3'd7) && !ss_rise;
  assign rx_byte   = {rx_sr, mosi_s2};
  assign word      = {hi_byte, rx_byte};
  assign busy      = (state != IDLE);
  assign spi_miso  = busy & miso_sr[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hi_byte  <= '0;
      addr     <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      swap_req <= 1'b0;
    end else begin
      state    <= state_n;
      hi_byte  <= hi_n;
      addr     <= addr_n;
      fb_we    <= fb_we_n;
      fb_addr  <= fb_addr_n;
      fb_data  <= fb_data_n;
      swap_req <= swap_n;
    end
  end

  always_comb begin
    state_n   = state;
    hi_n      = hi_byte;
    addr_n    = addr;
    fb_we_n   = 1'b0;
    fb_addr_n = fb_addr;
    fb_data_n = fb_data;
    swap_n    = 1'b0;
    if (state == IDLE) begin
      if (start) state_n = CMD;
    end else if (ss_rise) begin
      state_n = IDLE;
    end else if (byte_done) begin
      case (state)
        CMD: begin
          if (rx_byte == 8'h01) begin
            state_n = ADDR_HI;
          end else begin
            swap_n  = (rx_byte == 8'h02);
            state_n = IGNORE;
          end
        end
        ADDR_HI: begin
          hi_n    = rx_byte;
          state_n = ADDR_LO;
        end
        ADDR_LO: begin
          addr_n  = word[ADDR_WIDTH-1:0];
          state_n = DATA_HI;
        end
        DATA_HI: begin
          hi_n    = rx_byte;
          state_n = DATA_LO;
        end
        DATA_LO: begin
          fb_we_n   = 1'b1;
          fb_addr_n = addr;
          fb_data_n = word;
          addr_n    = addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          state_n   = DATA_HI;
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      ss_s1     <= 1'b0;
      ss_s2     <= 1'b0;
      ss_prev   <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      miso_sr   <= '0;
      last_byte <= '0;
      boundary  <= 1'b0;
    end else begin
      sclk_s1   <= spi_sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      ss_s1     <= spi_ss;
      ss_s2     <= ss_s1;
      ss_prev   <= ss_s2;
      mosi_s1   <= spi_mosi;
      mosi_s2   <= mosi_s1;
      // ss flops clear low so a transaction live across reset never looks like a fresh start
      if (ss_s2) armed <= 1'b1;
      if (sclk_rise) rx_sr <= rx_byte[6:0];
      if (state == IDLE || ss_rise) bit_cnt <= '0;
      else if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE) begin
        boundary <= 1'b0;
      end else if (byte_done) begin
        boundary  <= 1'b1;
        last_byte <= rx_byte;
      end else if (sclk_fall) begin
        boundary <= 1'b0;
      end
      if (start) miso_sr <= MAGIC;
      else if (state != IDLE && sclk_fall) miso_sr <= boundary ? last_byte : {miso_sr[6:0], 1'b0};
    end
  end

endmodule
